rs_multi_cdb: RTL and testbench
===============================

# rs_multi_cdb

Parametrised reservation station: a successor to the single-station design, generalised in depth, tag/data width and broadcast channel count. It sits between issue and a single execution unit. It allocates its own free slot, captures operands from the register file, the ROB or any of NUM_CDB result buses, and wakes waiting entries from all buses in parallel. It dispatches one ready entry per cycle through a valid/ready register stage that honours execution-unit back-pressure.

## Interface
- DEPTH, 8: number of entries, power of two, ≥2
- IDX_W, 3: log2(DEPTH)
- ROB_IDX_W, 4: ROB tag width; tag 0 means "no dependency"
- WORD_W, 32: operand width
- OP_W, 6: instruction id width
- IMM_W, 32: immediate width
- ADDR_W, 32: pc width
- NUM_CDB, 2: number of result broadcast channels, ≥1

- clk_in  in  1  clock, rising edge
- rst_n_in  in  1  asynchronous active-low reset
- rdy_in  in  1  global enable; when low, all state holds
- flush_in  in  1  synchronous branch-mispredict clear
- alloc_valid_in  in  1  issue presents an instruction
- alloc_ready_out  out  1  a free entry exists (combinational from busy vector)
- alloc_op_in / alloc_imm_in / alloc_pc_in / alloc_rob_in  in  OP_W / IMM_W / ADDR_W / ROB_IDX_W  instruction fields
- alloc_q1_in, alloc_q2_in  in  ROB_IDX_W  source tags; 0 = value supplied
- alloc_v1_in, alloc_v2_in  in  WORD_W  source values, valid when tag is 0
- cdb_valid_in  in  NUM_CDB  per-channel broadcast valid
- cdb_tag_in  in  NUM_CDB*ROB_IDX_W  packed tags; channel c at [c*ROB_IDX_W +: ROB_IDX_W]
- cdb_data_in  in  NUM_CDB*WORD_W  packed results
- disp_valid_out  out  1  dispatch register holds an instruction
- disp_ready_in  in  1  execution unit accepts this cycle
- disp_op_out / disp_imm_out / disp_pc_out / disp_rob_out / disp_v1_out / disp_v2_out  out  as above  dispatched fields
- occupancy_out  out  IDX_W+1  number of busy entries

## Operation
- Allocation: if alloc_valid_in && alloc_ready_out, write to the lowest-index free slot and set busy.
- Per source at allocation: tag 0 → store the value. Otherwise, if any cdb_valid_in[c] with a matching tag → store that data and set q=0; lowest c wins on a multi-match. Otherwise store the tag.
- Wakeup: every busy entry compares q1 and q2 against every valid channel. On a match, capture the data and clear q; lowest channel wins.
- Ready entry: busy && q1==0 && q2==0. Entries allocated or woken this cycle become eligible from the next cycle.
- Dispatch register load: when !disp_valid_out || disp_ready_in, and some entry is ready, select one entry, copy it to the dispatch outputs, clear its busy bit, and set disp_valid_out.
- If disp_ready_in && no entry is ready, disp_valid_out clears.
- The dispatch outputs hold stable while disp_valid_out && !disp_ready_in.
- Same-cycle alloc and dispatch: allocation uses the free set from before the edge. A slot freed by dispatch is reusable next cycle.
- Flush: clears all busy bits, disp_valid_out and occupancy. It takes priority over alloc, wakeup and dispatch in the same cycle.
- occupancy_out = popcount(busy), registered alongside busy.

## Timing
- Reset (async assert): busy=0, disp_valid_out=0, all disp_*_out=0, occupancy_out=0, alloc_ready_out=1. Age state is cleared. Reset mid-operation discards all entries.
- Minimum latency: alloc with both operands ready at edge t → disp_valid_out=1 after edge t+1.
- Wakeup latency: broadcast at edge t → entry eligible at edge t+1 → dispatched after edge t+1 if the register is free.
- Full: alloc_ready_out=0 when occupancy==DEPTH. An alloc_valid_in held high is ignored; no entry is overwritten.
- rdy_in low: no state changes; outputs hold.

## Configuration
- RS_AGE_ORDER_EN defined:
  - Maintain a DEPTH×DEPTH age matrix. On allocation of slot k, row k ← current busy vector (every busy entry is older than k).
  - Selection picks the ready entry with no older ready entry, i.e. the oldest ready entry.
- RS_AGE_ORDER_EN undefined: no age matrix; selection picks the lowest-index ready entry.
- Interface and latency are identical in both builds.

## Test plan
- Reset then single alloc: op=5, q1=q2=0, v1=3, v2=4 at edge 1 → disp_valid_out=1, disp_v1_out=3, disp_v2_out=4 after edge 2; occupancy returns to 0.
- Dependent wakeup on channel 1: alloc with q1=6 → cdb_valid_in=2'b10, tag 6, data 0xDEAD_BEEF one cycle later → dispatched v1=0xDEADBEEF one cycle after the broadcast. Repeat with the broadcast in the alloc cycle → captured at allocation.
- Fill all 8 entries with q1=7 → alloc_ready_out=0. A ninth alloc is ignored. Broadcast tag 7 → entries drain one per cycle; alloc_ready_out=1 after the first dispatch.
- Back-pressure: hold disp_ready_in=0 for 5 cycles with 2 ready entries → outputs stable, occupancy stays at 1. Raise disp_ready_in → the second entry is delivered on the next cycle.
- Ordering: allocate into slots 0,1,2 (all waiting), dispatch slot 0, allocate a new entry into slot 0, then wake all → RS_AGE_ORDER_EN gives order rob of slot 1,2,0; undefined gives 0,1,2.
- Flush with 4 busy entries, a concurrent alloc and disp_valid_out=1 → next cycle occupancy=0, disp_valid_out=0, alloc_ready_out=1. Async reset asserted mid-burst clears the same state immediately.

Source files
------------

// File: rtl/rs_multi_cdb.sv
// Reservation station with NUM_CDB broadcast channels and a registered valid/ready dispatch stage.
// Build option RS_AGE_ORDER_EN: dispatch the oldest ready entry instead of the lowest-index one.
module rs_multi_cdb #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDX_W     = 3,
  parameter int unsigned ROB_IDX_W = 4,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned OP_W      = 6,
  parameter int unsigned IMM_W     = 32,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned NUM_CDB   = 2
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic                         rdy_in,
  input  logic                         flush_in,
  input  logic                         alloc_valid_in,
  output logic                         alloc_ready_out,
  input  logic [OP_W-1:0]              alloc_op_in,
  input  logic [IMM_W-1:0]             alloc_imm_in,
  input  logic [ADDR_W-1:0]            alloc_pc_in,
  input  logic [ROB_IDX_W-1:0]         alloc_rob_in,
  input  logic [ROB_IDX_W-1:0]         alloc_q1_in,
  input  logic [ROB_IDX_W-1:0]         alloc_q2_in,
  input  logic [WORD_W-1:0]            alloc_v1_in,
  input  logic [WORD_W-1:0]            alloc_v2_in,
  input  logic [NUM_CDB-1:0]           cdb_valid_in,
  input  logic [NUM_CDB*ROB_IDX_W-1:0] cdb_tag_in,
  input  logic [NUM_CDB*WORD_W-1:0]    cdb_data_in,
  output logic                         disp_valid_out,
  input  logic                         disp_ready_in,
  output logic [OP_W-1:0]              disp_op_out,
  output logic [IMM_W-1:0]             disp_imm_out,
  output logic [ADDR_W-1:0]            disp_pc_out,
  output logic [ROB_IDX_W-1:0]         disp_rob_out,
  output logic [WORD_W-1:0]            disp_v1_out,
  output logic [WORD_W-1:0]            disp_v2_out,
  output logic [IDX_W:0]               occupancy_out
);

  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [OP_W-1:0]      op_q  [DEPTH];
  logic [IMM_W-1:0]     imm_q [DEPTH];
  logic [ADDR_W-1:0]    pc_q  [DEPTH];
  logic [ROB_IDX_W-1:0] rob_q [DEPTH];
  logic [ROB_IDX_W-1:0] q1_q  [DEPTH], q1_d [DEPTH];
  logic [ROB_IDX_W-1:0] q2_q  [DEPTH], q2_d [DEPTH];
  logic [WORD_W-1:0]    v1_q  [DEPTH], v1_d [DEPTH];
  logic [WORD_W-1:0]    v2_q  [DEPTH], v2_d [DEPTH];
  logic [IDX_W:0]       occ_q, occ_d;

  logic                 disp_valid_q, disp_valid_d;
  logic [OP_W-1:0]      disp_op_q, disp_op_d;
  logic [IMM_W-1:0]     disp_imm_q, disp_imm_d;
  logic [ADDR_W-1:0]    disp_pc_q, disp_pc_d;
  logic [ROB_IDX_W-1:0] disp_rob_q, disp_rob_d;
  logic [WORD_W-1:0]    disp_v1_q, disp_v1_d;
  logic [WORD_W-1:0]    disp_v2_q, disp_v2_d;

  logic                 alloc_fire;
  logic [IDX_W-1:0]     alloc_idx;
  logic [ROB_IDX_W-1:0] a_q1, a_q2;
  logic [WORD_W-1:0]    a_v1, a_v2;
  logic [DEPTH-1:0]     ready;
  logic                 sel_any;
  logic [IDX_W-1:0]     sel_idx;
  logic                 load_en;

  assign alloc_ready_out = ~&busy_q;
  assign alloc_fire      = alloc_valid_in && alloc_ready_out;
  assign load_en         = !disp_valid_q || disp_ready_in;

  // Lowest free slot, and source operands resolved against the buses (lowest channel wins).
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) alloc_idx = IDX_W'(i);
    end
    a_q1 = alloc_q1_in;
    a_v1 = alloc_v1_in;
    a_q2 = alloc_q2_in;
    a_v2 = alloc_v2_in;
    for (int c = NUM_CDB - 1; c >= 0; c--) begin
      if (cdb_valid_in[c]) begin
        if (alloc_q1_in != '0 && alloc_q1_in == cdb_tag_in[c*ROB_IDX_W +: ROB_IDX_W]) begin
          a_q1 = '0;
          a_v1 = cdb_data_in[c*WORD_W +: WORD_W];
        end
        if (alloc_q2_in != '0 && alloc_q2_in == cdb_tag_in[c*ROB_IDX_W +: ROB_IDX_W]) begin
          a_q2 = '0;
          a_v2 = cdb_data_in[c*WORD_W +: WORD_W];
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ready[i] = busy_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0);
    end
  end

`ifdef RS_AGE_ORDER_EN
  // age_q[k][j] set means entry j is older than entry k.
  logic [DEPTH-1:0] age_q [DEPTH];

  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i] && ((age_q[i] & ready) == '0)) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
    end else if (rdy_in) begin
      if (flush_in) begin
        for (int i = 0; i < DEPTH; i++) age_q[i] <= '0;
      end else if (alloc_fire) begin
        // A reused slot must stop looking older than anyone allocated before its reuse.
        for (int r = 0; r < DEPTH; r++) age_q[r][alloc_idx] <= 1'b0;
        age_q[alloc_idx] <= busy_q;
      end
    end
  end
`else
  always_comb begin
    sel_any = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        sel_any = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end
`endif

  always_comb begin
    busy_d       = busy_q;
    q1_d         = q1_q;
    q2_d         = q2_q;
    v1_d         = v1_q;
    v2_d         = v2_q;
    disp_valid_d = disp_valid_q;
    disp_op_d    = disp_op_q;
    disp_imm_d   = disp_imm_q;
    disp_pc_d    = disp_pc_q;
    disp_rob_d   = disp_rob_q;
    disp_v1_d    = disp_v1_q;
    disp_v2_d    = disp_v2_q;

    for (int i = 0; i < DEPTH; i++) begin
      for (int c = NUM_CDB - 1; c >= 0; c--) begin
        if (busy_q[i] && cdb_valid_in[c]) begin
          if (q1_q[i] != '0 && q1_q[i] == cdb_tag_in[c*ROB_IDX_W +: ROB_IDX_W]) begin
            q1_d[i] = '0;
            v1_d[i] = cdb_data_in[c*WORD_W +: WORD_W];
          end
          if (q2_q[i] != '0 && q2_q[i] == cdb_tag_in[c*ROB_IDX_W +: ROB_IDX_W]) begin
            q2_d[i] = '0;
            v2_d[i] = cdb_data_in[c*WORD_W +: WORD_W];
          end
        end
      end
    end

    if (alloc_fire) begin
      busy_d[alloc_idx] = 1'b1;
      q1_d[alloc_idx]   = a_q1;
      q2_d[alloc_idx]   = a_q2;
      v1_d[alloc_idx]   = a_v1;
      v2_d[alloc_idx]   = a_v2;
    end

    if (load_en && sel_any) begin
      busy_d[sel_idx] = 1'b0;
      disp_valid_d    = 1'b1;
      disp_op_d       = op_q[sel_idx];
      disp_imm_d      = imm_q[sel_idx];
      disp_pc_d       = pc_q[sel_idx];
      disp_rob_d      = rob_q[sel_idx];
      disp_v1_d       = v1_q[sel_idx];
      disp_v2_d       = v2_q[sel_idx];
    end else if (disp_ready_in) begin
      disp_valid_d = 1'b0;
    end

    if (flush_in) begin
      busy_d       = '0;
      disp_valid_d = 1'b0;
    end

    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) occ_d = occ_d + (IDX_W + 1)'(busy_d[i]);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q       <= '0;
      occ_q        <= '0;
      disp_valid_q <= 1'b0;
      disp_op_q    <= '0;
      disp_imm_q   <= '0;
      disp_pc_q    <= '0;
      disp_rob_q   <= '0;
      disp_v1_q    <= '0;
      disp_v2_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        imm_q[i] <= '0;
        pc_q[i]  <= '0;
        rob_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
      end
    end else if (rdy_in) begin
      busy_q       <= busy_d;
      occ_q        <= occ_d;
      disp_valid_q <= disp_valid_d;
      disp_op_q    <= disp_op_d;
      disp_imm_q   <= disp_imm_d;
      disp_pc_q    <= disp_pc_d;
      disp_rob_q   <= disp_rob_d;
      disp_v1_q    <= disp_v1_d;
      disp_v2_q    <= disp_v2_d;
      q1_q         <= q1_d;
      q2_q         <= q2_d;
      v1_q         <= v1_d;
      v2_q         <= v2_d;
      if (alloc_fire) begin
        op_q[alloc_idx]  <= alloc_op_in;
        imm_q[alloc_idx] <= alloc_imm_in;
        pc_q[alloc_idx]  <= alloc_pc_in;
        rob_q[alloc_idx] <= alloc_rob_in;
      end
    end
  end

  assign disp_valid_out = disp_valid_q;
  assign disp_op_out    = disp_op_q;
  assign disp_imm_out   = disp_imm_q;
  assign disp_pc_out    = disp_pc_q;
  assign disp_rob_out   = disp_rob_q;
  assign disp_v1_out    = disp_v1_q;
  assign disp_v2_out    = disp_v2_q;
  assign occupancy_out  = occ_q;

endmodule

// File: tb/tb_rs_multi_cdb.sv
// Directed self-checking bench for rs_multi_cdb (default parameters, two CDB channels).
module tb_rs_multi_cdb;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        flush_in;
  logic        alloc_valid_in;
  logic        alloc_ready_out;
  logic [5:0]  alloc_op_in;
  logic [31:0] alloc_imm_in;
  logic [31:0] alloc_pc_in;
  logic [3:0]  alloc_rob_in;
  logic [3:0]  alloc_q1_in;
  logic [3:0]  alloc_q2_in;
  logic [31:0] alloc_v1_in;
  logic [31:0] alloc_v2_in;
  logic [1:0]  cdb_valid_in;
  logic [7:0]  cdb_tag_in;
  logic [63:0] cdb_data_in;
  logic        disp_valid_out;
  logic        disp_ready_in;
  logic [5:0]  disp_op_out;
  logic [31:0] disp_imm_out;
  logic [31:0] disp_pc_out;
  logic [3:0]  disp_rob_out;
  logic [31:0] disp_v1_out;
  logic [31:0] disp_v2_out;
  logic [3:0]  occupancy_out;

  int n_checks = 0;
  int n_fail   = 0;

  rs_multi_cdb dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .rdy_in          (rdy_in),
    .flush_in        (flush_in),
    .alloc_valid_in  (alloc_valid_in),
    .alloc_ready_out (alloc_ready_out),
    .alloc_op_in     (alloc_op_in),
    .alloc_imm_in    (alloc_imm_in),
    .alloc_pc_in     (alloc_pc_in),
    .alloc_rob_in    (alloc_rob_in),
    .alloc_q1_in     (alloc_q1_in),
    .alloc_q2_in     (alloc_q2_in),
    .alloc_v1_in     (alloc_v1_in),
    .alloc_v2_in     (alloc_v2_in),
    .cdb_valid_in    (cdb_valid_in),
    .cdb_tag_in      (cdb_tag_in),
    .cdb_data_in     (cdb_data_in),
    .disp_valid_out  (disp_valid_out),
    .disp_ready_in   (disp_ready_in),
    .disp_op_out     (disp_op_out),
    .disp_imm_out    (disp_imm_out),
    .disp_pc_out     (disp_pc_out),
    .disp_rob_out    (disp_rob_out),
    .disp_v1_out     (disp_v1_out),
    .disp_v2_out     (disp_v2_out),
    .occupancy_out   (occupancy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1ns after the rising edge; outputs are sampled there too.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    alloc_valid_in = 1'b0;
    cdb_valid_in   = '0;
    flush_in       = 1'b0;
  endtask

  task automatic alloc(input logic [3:0] rob, input logic [3:0] q1, input logic [31:0] v1,
                       input logic [3:0] q2, input logic [31:0] v2);
    alloc_valid_in = 1'b1;
    alloc_op_in    = {2'b00, rob};
    alloc_imm_in   = 32'h100 + 32'(rob);
    alloc_pc_in    = 32'h4000 + 32'(rob);
    alloc_rob_in   = rob;
    alloc_q1_in    = q1;
    alloc_v1_in    = v1;
    alloc_q2_in    = q2;
    alloc_v2_in    = v2;
  endtask

  task automatic bcast(input logic [1:0] vld, input logic [3:0] t0, input logic [31:0] d0,
                       input logic [3:0] t1, input logic [31:0] d1);
    cdb_valid_in = vld;
    cdb_tag_in   = {t1, t0};
    cdb_data_in  = {d1, d0};
  endtask

  logic [3:0] exp_order [3];

  initial begin
    rst_n_in      = 1'b0;
    rdy_in        = 1'b1;
    disp_ready_in = 1'b1;
    idle();
    alloc(4'd0, 4'd0, 32'd0, 4'd0, 32'd0);
    alloc_valid_in = 1'b0;
    bcast(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    tick();
    tick();
    check_eq("reset_occ", 64'(occupancy_out), 64'd0);
    check_eq("reset_ready", 64'(alloc_ready_out), 64'd1);
    check_eq("reset_dvalid", 64'(disp_valid_out), 64'd0);
    check_eq("reset_dv1", 64'(disp_v1_out), 64'd0);
    rst_n_in = 1'b1;
    tick();

    // Single ready alloc: dispatched after the following edge.
    alloc(4'd1, 4'd0, 32'd3, 4'd0, 32'd4);
    alloc_op_in = 6'd5;
    tick();
    idle();
    check_eq("single_occ1", 64'(occupancy_out), 64'd1);
    check_eq("single_dvalid0", 64'(disp_valid_out), 64'd0);
    tick();
    check_eq("single_dvalid", 64'(disp_valid_out), 64'd1);
    check_eq("single_op", 64'(disp_op_out), 64'd5);
    check_eq("single_v1", 64'(disp_v1_out), 64'd3);
    check_eq("single_v2", 64'(disp_v2_out), 64'd4);
    check_eq("single_occ0", 64'(occupancy_out), 64'd0);
    tick();
    check_eq("single_drop", 64'(disp_valid_out), 64'd0);

    // rdy_in low freezes everything.
    rdy_in = 1'b0;
    alloc(4'd2, 4'd0, 32'd1, 4'd0, 32'd1);
    tick();
    tick();
    check_eq("hold_occ", 64'(occupancy_out), 64'd0);
    check_eq("hold_dvalid", 64'(disp_valid_out), 64'd0);
    idle();
    rdy_in = 1'b1;

    // Wakeup on channel 1 one cycle after allocation.
    alloc(4'd2, 4'd6, 32'd0, 4'd0, 32'd9);
    tick();
    idle();
    bcast(2'b10, 4'd0, 32'd0, 4'd6, 32'hDEAD_BEEF);
    tick();
    bcast(2'b00, 4'd0, 32'd0, 4'd0, 32'd0);
    check_eq("wake_not_yet", 64'(disp_valid_out), 64'd0);
    tick();
    check_eq("wake_dvalid", 64'(disp_valid_out), 64'd1);
    check_eq("wake_v1", 64'(disp_v1_out), 64'hDEAD_BEEF);
    check_eq("wake_v2", 64'(disp_v2_out), 64'd9);
    check_eq("wake_rob", 64'(disp_rob_out), 64'd2);
    tick();

    // Broadcast in the alloc cycle, both channels match: channel 0 wins.
    alloc(4'd3, 4'd6, 32'd0, 4'd0, 32'd8);
    bcast(2'b11, 4'd6, 32'h1111, 4'd6, 32'h2222);
    tick();
    idle();
    tick();
    check_eq("cap_dvalid", 64'(disp_valid_out), 64'd1);
    check_eq("cap_v1", 64'(disp_v1_out), 64'h1111);
    tick();

    // Fill all eight entries waiting on tag 7.
    for (int i = 0; i < 8; i++) begin
      alloc(4'(i + 1), 4'd7, 32'd0, 4'd0, 32'd0);
      tick();
    end
    check_eq("full_ready", 64'(alloc_ready_out), 64'd0);
    check_eq("full_occ", 64'(occupancy_out), 64'd8);
    alloc(4'd15, 4'd0, 32'd5, 4'd0, 32'd5);
    tick();
    idle();
    check_eq("full_ignored_occ", 64'(occupancy_out), 64'd8);
    check_eq("full_no_disp", 64'(disp_valid_out), 64'd0);
    bcast(2'b01, 4'd7, 32'h77, 4'd0, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("drain_dvalid", 64'(disp_valid_out), 64'd1);
      check_eq("drain_rob", 64'(disp_rob_out), 64'(i + 1));
      check_eq("drain_v1", 64'(disp_v1_out), 64'h77);
      if (i == 0) begin
        check_eq("drain_occ7", 64'(occupancy_out), 64'd7);
        check_eq("drain_ready", 64'(alloc_ready_out), 64'd1);
      end
    end
    tick();
    check_eq("drain_done", 64'(disp_valid_out), 64'd0);
    check_eq("drain_occ0", 64'(occupancy_out), 64'd0);

    // Back-pressure with two ready entries.
    disp_ready_in = 1'b0;
    alloc(4'd3, 4'd0, 32'hA, 4'd0, 32'd0);
    tick();
    alloc(4'd4, 4'd0, 32'hB, 4'd0, 32'd0);
    tick();
    idle();
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("bp_dvalid", 64'(disp_valid_out), 64'd1);
      check_eq("bp_rob", 64'(disp_rob_out), 64'd3);
      check_eq("bp_v1", 64'(disp_v1_out), 64'hA);
      check_eq("bp_occ", 64'(occupancy_out), 64'd1);
    end
    disp_ready_in = 1'b1;
    tick();
    check_eq("bp_second_rob", 64'(disp_rob_out), 64'd4);
    check_eq("bp_second_v1", 64'(disp_v1_out), 64'hB);
    check_eq("bp_occ0", 64'(occupancy_out), 64'd0);
    tick();

    // Ordering after slot 0 is reused.
    alloc(4'd1, 4'd1, 32'd0, 4'd0, 32'd0);
    tick();
    alloc(4'd2, 4'd5, 32'd0, 4'd0, 32'd0);
    tick();
    alloc(4'd3, 4'd5, 32'd0, 4'd0, 32'd0);
    tick();
    idle();
    bcast(2'b01, 4'd1, 32'd0, 4'd0, 32'd0);
    tick();
    idle();
    tick();
    check_eq("ord_first_rob", 64'(disp_rob_out), 64'd1);
    alloc(4'd9, 4'd5, 32'd0, 4'd0, 32'd0);
    tick();
    idle();
    bcast(2'b01, 4'd5, 32'h55, 4'd0, 32'd0);
    tick();
    idle();
`ifdef RS_AGE_ORDER_EN
    exp_order[0] = 4'd2;
    exp_order[1] = 4'd3;
    exp_order[2] = 4'd9;
`else
    exp_order[0] = 4'd9;
    exp_order[1] = 4'd2;
    exp_order[2] = 4'd3;
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("ord_dvalid", 64'(disp_valid_out), 64'd1);
      check_eq("ord_rob", 64'(disp_rob_out), 64'(exp_order[i]));
    end
    tick();

    // Flush with four busy entries, a held dispatch and a concurrent alloc.
    disp_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alloc(4'(i + 1), 4'd0, 32'd1, 4'd0, 32'd2);
      tick();
    end
    check_eq("pre_flush_occ", 64'(occupancy_out), 64'd4);
    check_eq("pre_flush_dvalid", 64'(disp_valid_out), 64'd1);
    flush_in = 1'b1;
    alloc(4'd12, 4'd0, 32'd1, 4'd0, 32'd2);
    tick();
    idle();
    check_eq("flush_occ", 64'(occupancy_out), 64'd0);
    check_eq("flush_dvalid", 64'(disp_valid_out), 64'd0);
    check_eq("flush_ready", 64'(alloc_ready_out), 64'd1);
    disp_ready_in = 1'b1;
    tick();
    check_eq("flush_stays", 64'(occupancy_out), 64'd0);

    // Async reset mid-burst.
    disp_ready_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alloc(4'(i + 1), 4'd0, 32'd7, 4'd0, 32'd7);
      tick();
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("arst_occ", 64'(occupancy_out), 64'd0);
    check_eq("arst_dvalid", 64'(disp_valid_out), 64'd0);
    check_eq("arst_ready", 64'(alloc_ready_out), 64'd1);
    check_eq("arst_rob", 64'(disp_rob_out), 64'd0);
    idle();
    tick();
    rst_n_in = 1'b1;
    tick();
    check_eq("arst_after", 64'(occupancy_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
